// File: rtl/mem_data_arbiter.sv
// Two-requester arbiter/sequencer for the OTTER memory data port.
// Registers each granted command, holds it through the data cycle and rejects misaligned accesses.
module mem_data_arbiter (
  input  logic        ARB_CLK,
  input  logic        ARB_RST_N,
  input  logic        RR_EN,
  input  logic        A_REQ,
  input  logic        A_WE,
  input  logic [31:0] A_ADDR,
  input  logic [31:0] A_DIN,
  input  logic [1:0]  A_SIZE,
  input  logic        A_SIGN,
  input  logic        B_REQ,
  input  logic        B_WE,
  input  logic [31:0] B_ADDR,
  input  logic [31:0] B_DIN,
  input  logic [1:0]  B_SIZE,
  input  logic        B_SIGN,
  output logic        A_GNT,
  output logic        B_GNT,
  output logic        A_RVALID,
  output logic        B_RVALID,
  output logic        A_ERR,
  output logic        B_ERR,
  output logic [31:0] RDATA,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2,
  output logic [1:0]  DBG_STATE
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_we_q, cmd_we_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_din_q, cmd_din_d;
  logic [1:0]  cmd_size_q, cmd_size_d;
  logic        cmd_sign_q, cmd_sign_d;
  logic        cmd_err_q, cmd_err_d;
  logic        owner_q, owner_d;   // 0 = A, 1 = B
  logic        last_q, last_d;     // most recent winner, 0 = A, 1 = B
  logic        a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic        a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic        a_err_q, a_err_d, b_err_q, b_err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        pick_b;
  logic [31:0] sel_addr;
  logic [1:0]  sel_size;
  logic        sel_mis;
  logic        active;

  // Handshake: a requester raises REQ with its command and holds it until it sees
  // its one-cycle GNT; REQ is only sampled in IDLE, so it must change or drop the cycle after GNT.
  assign pick_b   = B_REQ & (~A_REQ | (RR_EN & ~last_q));
  assign sel_addr = pick_b ? B_ADDR : A_ADDR;
  assign sel_size = pick_b ? B_SIZE : A_SIZE;
  assign sel_mis  = (sel_size == 2'd3) |
                    ((sel_size == 2'd1) & (sel_addr[1:0] == 2'd3)) |
                    ((sel_size == 2'd2) & (sel_addr[1:0] != 2'd0));

  always_comb begin
    state_d    = state_q;
    cmd_we_d   = cmd_we_q;
    cmd_addr_d = cmd_addr_q;
    cmd_din_d  = cmd_din_q;
    cmd_size_d = cmd_size_q;
    cmd_sign_d = cmd_sign_q;
    cmd_err_d  = cmd_err_q;
    owner_d    = owner_q;
    last_d     = last_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_err_d    = 1'b0;
    b_err_d    = 1'b0;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (A_REQ | B_REQ) begin
          cmd_we_d   = pick_b ? B_WE : A_WE;
          cmd_addr_d = sel_addr;
          cmd_din_d  = pick_b ? B_DIN : A_DIN;
          cmd_size_d = sel_size;
          cmd_sign_d = pick_b ? B_SIGN : A_SIGN;
          cmd_err_d  = sel_mis;
          owner_d    = pick_b;
          last_d     = pick_b;
          a_gnt_d    = ~pick_b;
          b_gnt_d    = pick_b;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = (~cmd_we_q | cmd_err_q) ? ST_DATA : ST_IDLE;
      end
      ST_DATA: begin
        rdata_d    = cmd_err_q ? 32'd0 : MEM_DOUT2;
        a_rvalid_d = ~owner_q;
        b_rvalid_d = owner_q;
        a_err_d    = ~owner_q & cmd_err_q;
        b_err_d    = owner_q & cmd_err_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ARB_CLK) begin
    if (!ARB_RST_N) begin
      state_q    <= ST_IDLE;
      cmd_we_q   <= 1'b0;
      cmd_addr_q <= 32'd0;
      cmd_din_q  <= 32'd0;
      cmd_size_q <= 2'd0;
      cmd_sign_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cmd_we_q   <= cmd_we_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_din_q  <= cmd_din_d;
      cmd_size_q <= cmd_size_d;
      cmd_sign_q <= cmd_sign_d;
      cmd_err_q  <= cmd_err_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_err_q    <= a_err_d;
      b_err_q    <= b_err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Address/size/sign stay up through DATA since memory-side sizing is combinational on them;
  // strobes are gated by reset so nothing commits on a reset edge.
  assign active    = (state_q == ST_ACCESS) | (state_q == ST_DATA);
  assign MEM_ADDR2 = active ? cmd_addr_q : 32'd0;
  assign MEM_DIN2  = active ? cmd_din_q : 32'd0;
  assign MEM_SIZE  = active ? cmd_size_q : 2'd0;
  assign MEM_SIGN  = active & cmd_sign_q;
  assign MEM_WE2   = (state_q == ST_ACCESS) & cmd_we_q & ~cmd_err_q & ARB_RST_N;
  assign MEM_RDEN2 = (state_q == ST_ACCESS) & ~cmd_we_q & ~cmd_err_q & ARB_RST_N;

  assign A_GNT     = a_gnt_q;
  assign B_GNT     = b_gnt_q;
  assign A_RVALID  = a_rvalid_q;
  assign B_RVALID  = b_rvalid_q;
  assign A_ERR     = a_err_q;
  assign B_ERR     = b_err_q;
  assign RDATA     = rdata_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Directed bench for mem_data_arbiter with a small byte-addressed memory model on port 2.
module tb_mem_data_arbiter;

  logic        ARB_CLK = 1'b0;
  logic        ARB_RST_N, RR_EN;
  logic        A_REQ, A_WE, A_SIGN, B_REQ, B_WE, B_SIGN;
  logic [31:0] A_ADDR, A_DIN, B_ADDR, B_DIN;
  logic [1:0]  A_SIZE, B_SIZE;
  logic        A_GNT, B_GNT, A_RVALID, B_RVALID, A_ERR, B_ERR;
  logic [31:0] RDATA, MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
  logic        MEM_RDEN2, MEM_WE2, MEM_SIGN;
  logic [1:0]  MEM_SIZE, DBG_STATE;

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset
  always #5 ARB_CLK = ~ARB_CLK;

  mem_data_arbiter dut (
    .ARB_CLK(ARB_CLK), .ARB_RST_N(ARB_RST_N), .RR_EN(RR_EN),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DIN(A_DIN), .A_SIZE(A_SIZE), .A_SIGN(A_SIGN),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DIN(B_DIN), .B_SIZE(B_SIZE), .B_SIGN(B_SIGN),
    .A_GNT(A_GNT), .B_GNT(B_GNT), .A_RVALID(A_RVALID), .B_RVALID(B_RVALID),
    .A_ERR(A_ERR), .B_ERR(B_ERR), .RDATA(RDATA),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2), .DBG_STATE(DBG_STATE)
  );

  // memory model: synchronous word read, combinational sizing on ADDR/SIZE/SIGN
  logic [31:0] mem [0:4095];
  logic [31:0] rd_word = 32'd0;

  function automatic logic [31:0] size_data(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    return uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  always @(posedge ARB_CLK) begin
    if (MEM_WE2) begin
      for (int i = 0; i < 4; i++) begin
        if ((MEM_SIZE == 2'd2) ||
            (MEM_SIZE == 2'd1 && (i / 2) == int'(MEM_ADDR2[1])) ||
            (MEM_SIZE == 2'd0 && i == int'(MEM_ADDR2[1:0])))
          mem[MEM_ADDR2[13:2]][8*i +: 8] <= (MEM_SIZE == 2'd2) ? MEM_DIN2[8*i +: 8] :
                                            (MEM_SIZE == 2'd1) ? MEM_DIN2[8*(i%2) +: 8] :
                                            MEM_DIN2[7:0];
      end
    end
    if (MEM_RDEN2) rd_word <= mem[MEM_ADDR2[13:2]];
  end

  always_comb MEM_DOUT2 = size_data(rd_word, MEM_ADDR2[1:0], MEM_SIZE, MEM_SIGN);

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // driver tasks
  task automatic step();
    @(posedge ARB_CLK);
    #1;
  endtask

  task automatic set_a(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] din, input logic [1:0] sz, input logic uns);
    A_REQ = req; A_WE = we; A_ADDR = addr; A_DIN = din; A_SIZE = sz; A_SIGN = uns;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] din, input logic [1:0] sz, input logic uns);
    B_REQ = req; B_WE = we; B_ADDR = addr; B_DIN = din; B_SIZE = sz; B_SIGN = uns;
  endtask

  // single A load: grant after one edge, data two edges later
  task automatic a_load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] exp);
    set_a(1'b1, 1'b0, addr, 32'd0, sz, uns);
    step();
    chk({tag, "_gnt"}, {30'd0, A_GNT, MEM_RDEN2}, 32'd3);
    A_REQ = 1'b0;
    step();
    chk({tag, "_data_cyc"}, {A_RVALID, MEM_RDEN2, MEM_ADDR2[29:0]}, {2'b00, addr[29:0]});
    step();
    chk({tag, "_rvalid"}, {30'd0, A_RVALID, A_ERR}, 32'd2);
    chk({tag, "_rdata"}, RDATA, exp);
  endtask

  logic [3:0] rr_exp [12] = '{4'b1000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0001,
                              4'b1000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0001};
  logic [3:0] fp_exp [12] = '{4'b1000, 4'b0000, 4'b0010, 4'b1000, 4'b0000, 4'b0010,
                              4'b1000, 4'b0000, 4'b0010, 4'b1000, 4'b0000, 4'b0010};

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem[12'h800] = 32'h11223344;   // 0x2000
    mem[12'h400] = 32'hCAFEF00D;   // 0x1000
    mem[12'hC00] = 32'hA5A5A5A5;   // 0x3000

    // reset held 3 cycles with both requesting
    ARB_RST_N = 1'b0;
    RR_EN = 1'b1;
    set_a(1'b1, 1'b0, 32'h2000, 32'd0, 2'd2, 1'b0);
    set_b(1'b1, 1'b0, 32'h2000, 32'd0, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_gnt", {30'd0, A_GNT, B_GNT}, 32'd0);
    end
    chk("rst_flags", {24'd0, A_RVALID, B_RVALID, A_ERR, B_ERR, MEM_WE2, MEM_RDEN2, MEM_SIGN, 1'b0}, 32'd0);
    chk("rst_addr", MEM_ADDR2 | MEM_DIN2 | {30'd0, MEM_SIZE}, 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_state", {30'd0, DBG_STATE}, 32'd0);

    // release: A wins the first contention
    ARB_RST_N = 1'b1;
    step();
    chk("first_gnt", {30'd0, A_GNT, B_GNT}, 32'd2);
    A_REQ = 1'b0; B_REQ = 1'b0;
    step();
    step();
    chk("first_rvalid", {30'd0, A_RVALID, B_RVALID}, 32'd2);
    chk("first_rdata", RDATA, 32'h11223344);

    // store word on A, commits at the edge closing the grant cycle
    set_a(1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 2'd2, 1'b0);
    step();
    chk("sw_gnt_we", {30'd0, A_GNT, MEM_WE2}, 32'd3);
    chk("sw_addr", MEM_ADDR2, 32'h2004);
    chk("sw_din", MEM_DIN2, 32'hDEADBEEF);
    A_REQ = 1'b0;
    step();
    chk("sw_idle", {29'd0, A_RVALID, MEM_WE2, DBG_STATE == 2'd0}, 32'd1);
    chk("sw_mem", mem[12'h801], 32'hDEADBEEF);

    // sized loads from the stored word
    a_load("lb", 32'h2007, 2'd0, 1'b0, 32'hFFFFFFDE);
    step();
    chk("lb_rvalid_pulse", {31'd0, A_RVALID}, 32'd0);
    chk("rdata_hold", RDATA, 32'hFFFFFFDE);
    a_load("lhu", 32'h2006, 2'd1, 1'b1, 32'h0000DEAD);
    a_load("lh", 32'h2004, 2'd1, 1'b0, 32'hFFFFBEEF);
    a_load("lbu", 32'h2005, 2'd0, 1'b1, 32'h000000BE);

    // misaligned store from B
    set_b(1'b1, 1'b1, 32'h1002, 32'h55555555, 2'd2, 1'b0);
    step();
    chk("mis_gnt", {29'd0, B_GNT, MEM_WE2, MEM_RDEN2}, 32'd4);
    B_REQ = 1'b0;
    step();
    chk("mis_data_cyc", {29'd0, B_RVALID, MEM_WE2, MEM_RDEN2}, 32'd0);
    step();
    chk("mis_rvalid_err", {28'd0, A_RVALID, A_ERR, B_RVALID, B_ERR}, 32'd3);
    chk("mis_rdata", RDATA, 32'd0);
    chk("mis_mem", mem[12'h400], 32'hCAFEF00D);

    // round-robin contention (last winner is B)
    RR_EN = 1'b1;
    set_a(1'b1, 1'b0, 32'h2004, 32'd0, 2'd2, 1'b0);
    set_b(1'b1, 1'b0, 32'h2000, 32'd0, 2'd2, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("rr_k%0d", k), {28'd0, A_GNT, B_GNT, A_RVALID, B_RVALID}, {28'd0, rr_exp[k]});
      if (rr_exp[k][1]) chk("rr_rdata_a", RDATA, 32'hDEADBEEF);
      if (rr_exp[k][0]) chk("rr_rdata_b", RDATA, 32'h11223344);
    end

    // fixed priority: B starves until A drops
    RR_EN = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("fp_k%0d", k), {28'd0, A_GNT, B_GNT, A_RVALID, B_RVALID}, {28'd0, fp_exp[k]});
    end
    A_REQ = 1'b0;
    step();
    chk("fp_b_gnt", {30'd0, A_GNT, B_GNT}, 32'd1);
    B_REQ = 1'b0;
    step();
    step();
    chk("fp_b_rvalid", {30'd0, A_RVALID, B_RVALID}, 32'd1);
    chk("fp_b_rdata", RDATA, 32'h11223344);

    // reset during the ACCESS cycle of a store
    set_a(1'b1, 1'b1, 32'h3000, 32'h12345678, 2'd2, 1'b0);
    step();
    chk("rmid_we_pre", {30'd0, A_GNT, MEM_WE2}, 32'd3);
    ARB_RST_N = 1'b0;
    A_REQ = 1'b0;
    #1;
    chk("rmid_we_gated", {31'd0, MEM_WE2}, 32'd0);
    step();
    ARB_RST_N = 1'b1;
    chk("rmid_mem", mem[12'hC00], 32'hA5A5A5A5);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rmid_no_rvalid", {30'd0, A_RVALID, A_GNT}, 32'd0);
    end
    chk("rmid_rdata", RDATA, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
